// File: rtl/uart_frame_writer.sv
// Turns the uart_rx byte stream into framed, pixel-packed BRAM writes with sync hunting and a stall timeout.
// Define UART_FRAME_WRITER_DOUBLE_BUFFER_EN to ping-pong between two banks so the display only sees complete frames.
module uart_frame_writer #(
    parameter int         H_RES       = 640,
    parameter int         V_RES       = 480,
    parameter int         BPP_BYTES   = 1,
    parameter int         ADDR_W      = 19,
    parameter int         TIMEOUT_CYC = 500000,
    parameter logic [7:0] SYNC0       = 8'hAA,
    parameter logic [7:0] SYNC1       = 8'h55
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic                   wr_bank,
    output logic [8*BPP_BYTES-1:0] wr_data,
    output logic                   wr_en,
    output logic                   rd_bank,
    output logic                   frame_done,
    output logic                   err_timeout,
    output logic                   busy,
    output logic [7:0]             frame_count,
    output logic [1:0]             state_dbg
);

    localparam int N    = H_RES * V_RES;
    localparam int DW   = 8 * BPP_BYTES;
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, LOAD = 2'd2} state_t;

    state_t            state;
    state_t            state_next;
    logic [TO_W-1:0]   idle_cnt;
    logic [ADDR_W-1:0] pix_cnt;
    logic              phase;
    logic [DW-1:0]     pix_sr;

    logic              timeout_hit;
    logic              load_byte;
    logic              pix_last_byte;
    logic              frame_last;
    logic [DW-1:0]     pix_next;

    assign state_dbg = state;

    // Input handshake: rx_valid is a single-cycle strobe with no backpressure;
    // every strobe is consumed in the cycle it arrives, so back-to-back bytes are safe.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rx_valid && rx_data == SYNC0) state_next = SYNC;
            SYNC: begin
                if (rx_valid) begin
                    if (rx_data == SYNC1)      state_next = LOAD;
                    else if (rx_data != SYNC0) state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                if (load_byte && pix_last_byte && frame_last) state_next = IDLE;
                else if (timeout_hit)                         state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A byte arriving in the same cycle the limit is reached wins over the timeout.
    always_comb begin
        timeout_hit   = (state != IDLE) && !rx_valid && (idle_cnt == TO_W'(TIMEOUT_CYC));
        load_byte     = (state == LOAD) && rx_valid;
        pix_last_byte = (phase == 1'(BPP_BYTES - 1));
        frame_last    = (pix_cnt == ADDR_W'(N - 1));
        pix_next      = (pix_sr << 8) | DW'(rx_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt    <= '0;
            pix_cnt     <= '0;
            phase       <= 1'b0;
            pix_sr      <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_en       <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 8'd0;
            rd_bank     <= 1'b0;
`ifdef UART_FRAME_WRITER_DOUBLE_BUFFER_EN
            wr_bank     <= 1'b1;
`else
            wr_bank     <= 1'b0;
`endif
        end else begin
            wr_en       <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= timeout_hit;
            busy        <= (state_next != IDLE);

            if (rx_valid || state == IDLE || timeout_hit) idle_cnt <= '0;
            else if (idle_cnt != TO_W'(TIMEOUT_CYC))      idle_cnt <= idle_cnt + 1'b1;

            if (state == SYNC && rx_valid && rx_data == SYNC1) begin
                pix_cnt <= '0;
                phase   <= 1'b0;
            end

            if (load_byte) begin
                pix_sr <= pix_next;
                if (pix_last_byte) begin
                    wr_en   <= 1'b1;
                    wr_addr <= pix_cnt;
                    wr_data <= pix_next;
                    phase   <= 1'b0;
                    if (frame_last) begin
                        // Frame complete: publish it and flip banks at the same edge as the last write.
                        pix_cnt     <= '0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
`ifdef UART_FRAME_WRITER_DOUBLE_BUFFER_EN
                        rd_bank     <= ~rd_bank;
                        wr_bank     <= rd_bank;
`endif
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_frame_writer.md
# uart_frame_writer

Parametrised successor to the top-level UART-to-BRAM write logic: turns the byte stream from `uart_rx` into framed, pixel-packed BRAM writes. Hunts a two-byte sync header, packs 1 or 2 bytes per pixel, generates sequential write addresses, and times out on stalled transfers. Optionally double-buffers so VGA only ever displays a complete frame. Sits between `uart_rx` and the write port of `ram_2port`; `rd_bank` feeds the VGA read address MSB.

## Interface
- `H_RES`, 640, pixels per line
- `V_RES`, 480, lines per frame
- `BPP_BYTES`, 1, bytes per pixel (1 or 2 only)
- `ADDR_W`, 19, pixel address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES
- `TIMEOUT_CYC`, 500000, idle cycles allowed between bytes inside a frame (10 ms @ 50 MHz)
- `SYNC0`, 8'hAA, first header byte
- `SYNC1`, 8'h55, second header byte

- `clk` in 1: system clock (CLOCK_50 at top)
- `rst` in 1: synchronous, active-high reset
- `rx_data` in 8: byte from `uart_rx`
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid
- `wr_addr` out ADDR_W: pixel address within bank
- `wr_bank` out 1: bank select for write port (address MSB)
- `wr_data` out 8·BPP_BYTES: packed pixel
- `wr_en` out 1: one-cycle write strobe
- `rd_bank` out 1: bank the display must read
- `frame_done` out 1: one-cycle pulse, full frame written
- `err_timeout` out 1: one-cycle pulse, frame aborted on timeout
- `busy` out 1: high in SYNC or LOAD
- `frame_count` out 8: completed frames, wraps 255→0

## Operation
- N = H_RES·V_RES pixels per frame.
- FSM states: IDLE, SYNC, LOAD.
  - IDLE: `rx_valid` & byte==SYNC0 → SYNC; other bytes dropped.
  - SYNC: byte==SYNC1 → LOAD (pixel counter=0, byte phase=0); byte==SYNC0 → stay SYNC; other → IDLE.
  - LOAD: each byte shifts into the pixel register MSB-first (first byte lands in `wr_data[8·BPP_BYTES-1 -: 8]`). When byte phase reaches BPP_BYTES-1, issue write at `wr_addr`=pixel counter, then increment counter and clear phase. Write of pixel N-1 → IDLE.
- Header bytes are never written. Bytes after the final pixel are treated as IDLE traffic (resync required).
- Timeout: idle counter clears on every `rx_valid`, counts in SYNC/LOAD otherwise. On reaching TIMEOUT_CYC: pulse `err_timeout`, → IDLE, partial frame discarded (no bank swap, `frame_count` unchanged). Pixels already written stay in the write bank.
- Reset: state IDLE, counters 0, phase 0. Outputs: `wr_addr`=0, `wr_data`=0, `wr_en`=0, `wr_bank`=1 with macro and 0 without, `rd_bank`=0, `frame_done`=0, `err_timeout`=0, `busy`=0, `frame_count`=0. Reset mid-frame aborts silently with no pulses.
- Pixel counter is ADDR_W bits; it never exceeds N-1, so there is no wrap past N.

## Timing
- All outputs are registered.
- `wr_en`, `wr_addr`, and `wr_data` are valid in the cycle after the `rx_valid` carrying the pixel's last byte.
- `frame_done` is high in the same cycle as the final `wr_en`. `frame_count` increments and `rd_bank`/`wr_bank` toggle at that same edge.
- `err_timeout` asserts in the cycle after the idle counter reaches TIMEOUT_CYC; `busy` drops in that same cycle.
- Back-to-back `rx_valid` on consecutive cycles must be accepted without loss. UART rate makes this unnecessary in practice, but it is required.
- A `rx_valid` in the same cycle the timeout is reached takes precedence: no timeout, the byte is processed.

## Configuration
- `UART_FRAME_WRITER_DOUBLE_BUFFER_EN` defined:
  - `wr_bank` = ~`rd_bank`.
  - Banks swap on every `frame_done`.
  - BRAM depth is 2·2^ADDR_W.
- Not defined:
  - `wr_bank` and `rd_bank` are tied to 0.
  - Writes go straight to the displayed buffer, matching single-buffer behaviour.
  - `frame_done` and `frame_count` still operate.

## Test plan
- H_RES=4, V_RES=2, BPP_BYTES=1: send AA 55 00..07 → 8 `wr_en`, addr 0..7, data 00..07; `frame_done` with addr 7; `frame_count`=1; `rd_bank` 0→1 (macro on).
- BPP_BYTES=2, N=2: send AA 55 12 34 56 78 → writes {0,16'h1234}, {1,16'h5678}; exactly 2 `wr_en`.
- Sync hunt: send 13 AA AA 55 then 8 pixels → frame accepted. Send AA 13 55 → stays IDLE, no writes.
- TIMEOUT_CYC=100: send AA 55 00 01, then idle 100 cycles → `err_timeout` one pulse; `frame_count` 0; `rd_bank` unchanged; next good frame completes normally.
- Reset asserted after 3 pixels → all outputs at reset values next cycle; no `frame_done`/`err_timeout`; fresh frame then completes from addr 0.
- Two consecutive good frames, macro on → `rd_bank` 0→1→0; `frame_count`=2. Macro off → `rd_bank` and `wr_bank` remain 0.
